// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester transmit path: FSM state codes,
// the per-half-bit line encoder and counter sizing.
package manchester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  // A counter must hold at least 0..n-1 and never collapse to zero width.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // First half carries the bit, second half its complement (1 = high->low).
  function automatic logic encode(input logic b, input logic second_half, input logic invert);
    return (second_half ? ~b : b) ^ invert;
  endfunction

endpackage

// File: rtl/manchester_baud_gen.sv
// Half-bit timing: counts HALF_BIT_CYCLES clocks per half-bit and tracks which
// half of the bit period is on the line.
module manchester_baud_gen
  import manchester_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic bit_tick,
  output logic phase
);

  localparam int CW = cnt_width(HALF_BIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  assign half_tick = enable && (cnt_q == CNT_LAST);
  assign bit_tick  = half_tick && phase_q;
  assign phase     = phase_q;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, whatever order the blocks execute in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (enable) begin
      cnt_q   <= half_tick ? '0 : cnt_q + 1'b1;
      phase_q <= phase_q ^ half_tick;
    end
  end

endmodule

// File: rtl/manchester_tx_framer.sv
// Manchester frame transmitter: accepts a word on valid/ready, then sends an
// alternating preamble, the data bits and an idle guard gap.
module manchester_tx_framer
  import manchester_pkg::*;
#(
  parameter int   DATA_WIDTH      = 8,
  parameter int   HALF_BIT_CYCLES = 4,
  parameter int   PREAMBLE_BITS   = 8,
  parameter int   GAP_BITS        = 2,
  parameter int   MSB_FIRST       = 1,
  parameter logic INVERT_POLARITY = 1'b0,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  manchester_out,
  output logic                  tx_active,
  output logic                  frame_done
);

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_PREAMBLE = ST_PREAMBLE;
  localparam logic [1:0] S_DATA     = ST_DATA;
  localparam logic [1:0] S_GAP      = ST_GAP;

  localparam int BW = cnt_width(max3(PREAMBLE_BITS, DATA_WIDTH, GAP_BITS));
  localparam logic [BW-1:0] PRE_LAST  = BW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  line_q, line_d;
  logic                  done_q, done_d;
  logic                  accept, half_tick, bit_tick, phase, phase_nxt, cur_bit;

  assign accept = tx_valid && (state_q == S_IDLE);

  manchester_baud_gen #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .enable   (state_q != S_IDLE),
    .half_tick(half_tick),
    .bit_tick (bit_tick),
    .phase    (phase)
  );

  // The line is registered, so it is computed from next-cycle state and phase.
  assign phase_nxt = accept ? 1'b0 : (phase ^ half_tick);

  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d   = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_DATA;
          bit_cnt_d = '0;
          shreg_d   = tx_data;
        end
      end
      S_PREAMBLE: begin
        if (bit_tick) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (GAP_BITS > 0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_tick) begin
          if (bit_cnt_q == GAP_LAST) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Preamble starts with 1 on even bit indices; data comes from the shift end.
  always_comb begin
    cur_bit = (state_d == S_PREAMBLE) ? ~bit_cnt_d[0]
            : ((MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0]);
    line_d  = ((state_d == S_PREAMBLE) || (state_d == S_DATA))
            ? encode(cur_bit, phase_nxt, INVERT_POLARITY) : IDLE_LEVEL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      line_q    <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready       = (state_q == S_IDLE);
  assign tx_active      = (state_q == S_PREAMBLE) || (state_q == S_DATA);
  assign manchester_out = line_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_manchester_tx_framer.sv
// Bench for manchester_tx_framer: three configurations checked every cycle
// against a frame-offset model, plus hand-computed waveform points.
module tb_manchester_tx_framer;

  localparam int N = 3;
  // Configuration per instance: a = defaults, b = inverted/LSB-first/idle-high, c = minimal.
  localparam int C_D    [N] = '{8, 8, 4};
  localparam int C_H    [N] = '{4, 4, 1};
  localparam int C_P    [N] = '{8, 8, 0};
  localparam int C_G    [N] = '{2, 2, 0};
  localparam int C_MSB  [N] = '{1, 0, 1};
  localparam int C_INV  [N] = '{0, 1, 0};
  localparam int C_IDLE [N] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0][7:0] tx_data;
  logic [N-1:0]      tx_valid;
  logic line_a, line_b, line_c, rdy_a, rdy_b, rdy_c;
  logic act_a, act_b, act_c, done_a, done_b, done_c;
  logic [N-1:0] line_o, ready_o, active_o, done_o;

  assign line_o   = {line_c, line_b, line_a};
  assign ready_o  = {rdy_c, rdy_b, rdy_a};
  assign active_o = {act_c, act_b, act_a};
  assign done_o   = {done_c, done_b, done_a};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;
  bit chk_en = 1'b0;

  int         m_t    [N] = '{0, 0, 0};
  bit         m_busy [N] = '{0, 0, 0};
  bit         m_done [N] = '{0, 0, 0};
  logic [7:0] m_word [N] = '{8'h00, 8'h00, 8'h00};

  manchester_tx_framer dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(rdy_a), .manchester_out(line_a), .tx_active(act_a), .frame_done(done_a)
  );

  manchester_tx_framer #(
    .MSB_FIRST(0), .INVERT_POLARITY(1'b1), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(rdy_b), .manchester_out(line_b), .tx_active(act_b), .frame_done(done_b)
  );

  manchester_tx_framer #(
    .DATA_WIDTH(4), .HALF_BIT_CYCLES(1), .PREAMBLE_BITS(0), .GAP_BITS(0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2][3:0]), .tx_valid(tx_valid[2]),
    .tx_ready(rdy_c), .manchester_out(line_c), .tx_active(act_c), .frame_done(done_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int i);
    return (C_P[i] + C_D[i] + C_G[i]) * 2 * C_H[i];
  endfunction

  // Line level at cycle t (1-based) of a frame carrying word w.
  function automatic logic model_line(input int i, input logic [7:0] w, input int t);
    int k, bn, j;
    logic b;
    k  = (t - 1) / C_H[i];
    bn = k / 2;
    if (bn < C_P[i]) begin
      b = (bn % 2 == 0);
    end else if (bn < C_P[i] + C_D[i]) begin
      j = bn - C_P[i];
      b = (C_MSB[i] != 0) ? w[C_D[i] - 1 - j] : w[j];
    end else begin
      return (C_IDLE[i] != 0);
    end
    return b ^ (k % 2 == 1) ^ (C_INV[i] != 0);
  endfunction

  // Model: a frame is just a cycle offset since acceptance plus the captured word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          if (m_t[i] == frame_len(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end else begin
          m_done[i] <= 1'b0;
          if (tx_valid[i]) begin
            m_busy[i] <= 1'b1;
            m_t[i]    <= 1;
            m_word[i] <= tx_data[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("line%0d", i), line_o[i],
              m_busy[i] ? model_line(i, m_word[i], m_t[i]) : (C_IDLE[i] != 0));
        check($sformatf("ready%0d", i), ready_o[i], !m_busy[i]);
        check($sformatf("active%0d", i), active_o[i],
              m_busy[i] && (m_t[i] <= (C_P[i] + C_D[i]) * 2 * C_H[i]));
        check($sformatf("done%0d", i), done_o[i], m_done[i]);
      end
    end
  end

  // Present a word for one edge; afterwards we sit in cycle 1 of the frame.
  task automatic accept(input int i, input logic [7:0] w);
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic goto(input int c);
    while (cyc < acc + c - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] pat;
    tx_data  = '0;
    tx_valid = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_ready_a", rdy_a, 1'b1);
    check("rst_active_a", act_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_line_b", line_b, 1'b1);

    // Default frame of 0xA5 with 0x3C held valid throughout.
    accept(0, 8'hA5);
    tx_data[0] = 8'h3C;
    goto(1);   check("t1_pre0_hi", line_a, 1'b1);
    goto(5);   check("t1_pre0_lo", line_a, 1'b0);
    goto(9);   check("t1_pre1_lo", line_a, 1'b0);
    goto(13);  check("t1_pre1_hi", line_a, 1'b1);
    goto(65);  check("t1_d0_first", line_a, 1'b1);
    goto(69);  check("t1_d0_second", line_a, 1'b0);
    goto(73);  check("t1_d1_first", line_a, 1'b0);
    goto(77);  check("t1_d1_second", line_a, 1'b1);
    goto(128); check("t1_active_last", act_a, 1'b1);
    goto(129); check("t1_gap_line", line_a, 1'b0); check("t1_gap_active", act_a, 1'b0);
    goto(144); check("t1_ready_gap", rdy_a, 1'b0);
    goto(145); check("t1_done", done_a, 1'b1); check("t1_ready", rdy_a, 1'b1);
    goto(146); check("t2_done_clr", done_a, 1'b0); check("t2_busy", rdy_a, 1'b0);
    check("t2_pre_start", line_a, 1'b1);
    tx_valid[0] = 1'b0;
    goto(210); check("t2_d0", line_a, 1'b0);
    goto(226); check("t2_d2", line_a, 1'b1);
    goto(290); check("t2_done", done_a, 1'b1);

    // Data change mid-frame must not disturb 0xFF.
    goto(292);
    accept(0, 8'hFF);
    goto(20);  check("t3_ready20", rdy_a, 1'b0);
    tx_data[0] = 8'h00;
    goto(65);  check("t3_d0", line_a, 1'b1);
    goto(69);  check("t3_d0b", line_a, 1'b0);
    goto(100); check("t3_ready100", rdy_a, 1'b0);
    goto(121); check("t3_d7", line_a, 1'b1);
    goto(125); check("t3_d7b", line_a, 1'b0);
    goto(140); tx_valid[0] = 1'b0;
    goto(145); check("t3_done", done_a, 1'b1);

    // Reset mid-frame while the line is high.
    goto(148);
    accept(0, 8'h5A);
    tx_valid[0] = 1'b0;
    goto(45);  check("t6_pre_line", line_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_line", line_a, 1'b0);
    check("t6_async_active", act_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_ready", rdy_a, 1'b1);
    check("t6_active", act_a, 1'b0);
    check("t6_done", done_a, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    accept(0, 8'hC3);
    tx_valid[0] = 1'b0;
    goto(65);  check("t6_new_d0", line_a, 1'b1);
    goto(81);  check("t6_new_d2", line_a, 1'b0);
    goto(145); check("t6_new_done", done_a, 1'b1);

    // Inverted, idle-high, LSB-first instance.
    goto(147);
    check("t4_idle", line_b, 1'b1);
    accept(1, 8'h01);
    tx_valid[1] = 1'b0;
    goto(1);   check("t4_pre0", line_b, 1'b0);
    goto(5);   check("t4_pre0b", line_b, 1'b1);
    goto(65);  check("t4_d0_first", line_b, 1'b0);
    goto(69);  check("t4_d0_second", line_b, 1'b1);
    goto(73);  check("t4_d1_first", line_b, 1'b1);
    goto(77);  check("t4_d1_second", line_b, 1'b0);
    goto(130); check("t4_gap_line", line_b, 1'b1); check("t4_gap_active", act_b, 1'b0);
    goto(145); check("t4_done", done_b, 1'b1); check("t4_idle_after", line_b, 1'b1);

    // Minimal instance: no preamble, no gap, one cycle per half-bit.
    goto(147);
    accept(2, 8'h09);
    tx_valid[2] = 1'b0;
    pat = 8'b1001_0110;
    for (int c = 1; c <= 8; c++) begin
      goto(c);
      check($sformatf("t5_line_c%0d", c), line_c, pat[8 - c]);
    end
    goto(9);   check("t5_done", done_c, 1'b1); check("t5_ready", rdy_c, 1'b1);
    goto(10);  check("t5_done_clr", done_c, 1'b0);

    goto(13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
